// File: rtl/dram_port_arbiter_pkg.sv
// Shared types and constants for the two-port DRAM arbiter.
package dram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StCmd,
        StWait,
        StErrDone
    } state_e;

    localparam logic [3:0]  WE_B          = 4'b0001;
    localparam logic [3:0]  WE_H          = 4'b0011;
    localparam logic [3:0]  WE_W          = 4'b1111;
    localparam logic [31:0] ERR_RDATA_DEF = 32'hDEADBEEF;

    // A mask of zero is a read; anything else must be a byte, half or word write.
    function automatic logic we_legal(input logic [3:0] we);
        return (we == 4'b0000) || (we == WE_B) || (we == WE_H) || (we == WE_W);
    endfunction

endpackage

// File: rtl/dram_port_arbiter_if.sv
// One requester port of the DRAM arbiter: level request in, ack/done pulses out.
interface dram_port_arbiter_if;

    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  we;
    logic        ack;
    logic        done;
    logic [31:0] rdata;

    modport master (
        output req, addr, wdata, we,
        input  ack, done, rdata
    );

    modport slave (
        input  req, addr, wdata, we,
        output ack, done, rdata
    );

endinterface

// File: rtl/dram_port_arbiter_rr_arb2.sv
// Two-way grant selection with optional fixed priority and a round-robin pointer.
module dram_port_arbiter_rr_arb2 #(
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt
);

    logic prefer;

    always_comb begin
        gnt = ~req[0];
        if ((FIXED_PRIO == 0) && req[0] && req[1]) begin
            gnt = prefer;
        end
    end

    // Next contested grant goes to the port opposite the one just granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prefer <= 1'b0;
        end else if (take) begin
            prefer <= ~gnt;
        end
    end

endmodule

// File: rtl/dram_port_arbiter.sv
// Shares one single-word DRAM port between data-memory (port 0) and fetch/loader (port 1).
module dram_port_arbiter
    import dram_port_arbiter_pkg::*;
#(
    parameter int unsigned FIXED_PRIO  = 0,
    parameter int unsigned TIMEOUT_CYC = 4096,
    parameter logic [31:0] ERR_RDATA   = ERR_RDATA_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 calib_done,
    dram_port_arbiter_if.slave   p0,
    dram_port_arbiter_if.slave   p1,
    output logic                 dram_oe,
    output logic [31:0]          dram_addr,
    output logic [31:0]          dram_wdata,
    output logic [3:0]           dram_we,
    input  logic [31:0]          dram_rdata,
    input  logic                 dram_valid,
    input  logic                 dram_busy,
    output logic                 err_timeout,
    output logic                 err_proto
);

    localparam logic [31:0] WdLast = 32'(TIMEOUT_CYC) - 32'd1;

    state_e           state;
    logic             owner;
    logic [31:0]      wdog;
    logic [1:0]       ack_q;
    logic [1:0]       done_q;
    logic [1:0][31:0] rdata_q;

    logic [1:0]  req;
    logic        grant_ok;
    logic        win;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic [3:0]  sel_we;
    logic        wd_fire;

    assign req       = {p1.req, p0.req};
    assign grant_ok  = (state == StIdle) && calib_done && !dram_busy && (req != 2'b00);
    assign sel_addr  = win ? p1.addr  : p0.addr;
    assign sel_wdata = win ? p1.wdata : p0.wdata;
    assign sel_we    = win ? p1.we    : p0.we;
    assign wd_fire   = (TIMEOUT_CYC != 0) && (wdog == WdLast);

    dram_port_arbiter_rr_arb2 #(
        .FIXED_PRIO(FIXED_PRIO)
    ) u_arb (
        .clk  (clk),
        .rst  (rst),
        .req  (req),
        .take (grant_ok),
        .gnt  (win)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            owner       <= 1'b0;
            wdog        <= '0;
            ack_q       <= '0;
            done_q      <= '0;
            rdata_q     <= '0;
            dram_oe     <= 1'b0;
            dram_addr   <= '0;
            dram_wdata  <= '0;
            dram_we     <= '0;
            err_timeout <= 1'b0;
            err_proto   <= 1'b0;
        end else begin
            ack_q  <= '0;
            done_q <= '0;
            case (state)
                StIdle: begin
                    if (grant_ok) begin
                        owner      <= win;
                        dram_addr  <= sel_addr;
                        dram_wdata <= sel_wdata;
                        dram_we    <= sel_we;
                        ack_q[win] <= 1'b1;
                        // Illegal masks are acked but never reach the DRAM.
                        if (we_legal(sel_we)) begin
                            dram_oe <= 1'b1;
                            state   <= StCmd;
                        end else begin
                            err_proto <= 1'b1;
                            state     <= StErrDone;
                        end
                    end
                end
                StCmd: begin
                    dram_oe <= 1'b0;
                    wdog    <= '0;
                    state   <= StWait;
                end
                StWait: begin
                    if (!dram_busy) begin
                        done_q[owner] <= 1'b1;
                        if (dram_we == 4'b0000) begin
                            rdata_q[owner] <= dram_rdata;
                            if (!dram_valid) begin
                                err_proto <= 1'b1;
                            end
                        end
                        state <= StIdle;
                    end else if (wd_fire) begin
                        err_timeout    <= 1'b1;
                        done_q[owner]  <= 1'b1;
                        rdata_q[owner] <= ERR_RDATA;
                        state          <= StIdle;
                    end else begin
                        wdog <= wdog + 32'd1;
                    end
                end
                StErrDone: begin
                    done_q[owner]  <= 1'b1;
                    rdata_q[owner] <= ERR_RDATA;
                    state          <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    assign p0.ack   = ack_q[0];
    assign p1.ack   = ack_q[1];
    assign p0.done  = done_q[0];
    assign p1.done  = done_q[1];
    assign p0.rdata = rdata_q[0];
    assign p1.rdata = rdata_q[1];

endmodule

// File: tb/tb_dram_port_arbiter.sv
// Scoreboard bench: directed requests push expectations, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_dram_port_arbiter;

    logic clk = 1'b0;
    logic rst;
    logic calib_done;
    always #5 clk = ~clk;

    dram_port_arbiter_if a0 ();
    dram_port_arbiter_if a1 ();
    dram_port_arbiter_if b0 ();
    dram_port_arbiter_if b1 ();

    logic        a_oe, b_oe;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic [3:0]  a_we, b_we;
    logic [31:0] a_rdata, b_rdata;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_busy = 1'b0, b_busy = 1'b0;
    logic        a_eto, a_epr, b_eto, b_epr;

    dram_port_arbiter #(
        .FIXED_PRIO  (0),
        .TIMEOUT_CYC (16),
        .ERR_RDATA   (32'hDEADBEEF)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .calib_done  (calib_done),
        .p0          (a0),
        .p1          (a1),
        .dram_oe     (a_oe),
        .dram_addr   (a_addr),
        .dram_wdata  (a_wdata),
        .dram_we     (a_we),
        .dram_rdata  (a_rdata),
        .dram_valid  (a_valid),
        .dram_busy   (a_busy),
        .err_timeout (a_eto),
        .err_proto   (a_epr)
    );

    dram_port_arbiter #(
        .FIXED_PRIO  (1),
        .TIMEOUT_CYC (16),
        .ERR_RDATA   (32'hDEADBEEF)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .calib_done  (1'b1),
        .p0          (b0),
        .p1          (b1),
        .dram_oe     (b_oe),
        .dram_addr   (b_addr),
        .dram_wdata  (b_wdata),
        .dram_we     (b_we),
        .dram_rdata  (b_rdata),
        .dram_valid  (b_valid),
        .dram_busy   (b_busy),
        .err_timeout (b_eto),
        .err_proto   (b_epr)
    );

    // DRAM models: busy for lat cycles after the strobe, valid on the falling edge of reads.
    int          lat_a = 10;
    bit          stuck_a = 1'b0;
    logic [31:0] rdv_a = 32'h0;
    int          cnt_a = 0, cnt_b = 0;
    logic [3:0]  wel_a = 4'h0, wel_b = 4'h0;
    assign a_rdata = rdv_a;
    assign b_rdata = 32'h0;

    always @(posedge clk) begin
        a_valid <= 1'b0;
        if (a_oe) begin
            a_busy <= 1'b1;
            cnt_a  <= lat_a;
            wel_a  <= a_we;
        end else if (a_busy && !stuck_a) begin
            if (cnt_a <= 1) begin
                a_busy  <= 1'b0;
                a_valid <= (wel_a == 4'h0);
            end else begin
                cnt_a <= cnt_a - 1;
            end
        end
    end

    always @(posedge clk) begin
        b_valid <= 1'b0;
        if (b_oe) begin
            b_busy <= 1'b1;
            cnt_b  <= 2;
            wel_b  <= b_we;
        end else if (b_busy) begin
            if (cnt_b <= 1) begin
                b_busy  <= 1'b0;
                b_valid <= (wel_b == 4'h0);
            end else begin
                cnt_b <= cnt_b - 1;
            end
        end
    end

    typedef struct packed {
        logic        port;
        logic [31:0] rdata;
    } done_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  we;
    } cmd_t;

    logic        exp_ack[$];
    done_t       exp_done[$];
    cmd_t        exp_cmd[$];
    logic [31:0] cur[2];
    int n_cmp = 0, n_bad = 0;
    int cyc = 0, ack_cyc = 0, done_cyc = 0;
    int n_ack_a = 0, n_done_a = 0, n_oe_a = 0, nb0 = 0, nb1 = 0;
    logic prev_oe = 1'b0;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (a0.ack || a1.ack) begin
                n_ack_a++;
                ack_cyc = cyc;
                chk("ack_onehot", 32'(a0.ack & a1.ack), 32'd0);
                chk("ack_expected", 32'(exp_ack.size() != 0), 32'd1);
                if (exp_ack.size() != 0) chk("ack_port", 32'(a1.ack), 32'(exp_ack.pop_front()));
            end
            if (a_oe) begin
                cmd_t c;
                n_oe_a++;
                chk("oe_width", 32'(prev_oe), 32'd0);
                chk("cmd_expected", 32'(exp_cmd.size() != 0), 32'd1);
                if (exp_cmd.size() != 0) begin
                    c = exp_cmd.pop_front();
                    chk("dram_addr", a_addr, c.addr);
                    chk("dram_wdata", a_wdata, c.wdata);
                    chk("dram_we", 32'(a_we), 32'(c.we));
                end
            end
            if (a0.done || a1.done) begin
                done_t e;
                n_done_a++;
                done_cyc = cyc;
                chk("done_onehot", 32'(a0.done & a1.done), 32'd0);
                chk("done_expected", 32'(exp_done.size() != 0), 32'd1);
                if (exp_done.size() != 0) begin
                    e = exp_done.pop_front();
                    chk("done_port", 32'(a1.done), 32'(e.port));
                    chk("done_rdata", e.port ? a1.rdata : a0.rdata, e.rdata);
                    chk("other_rdata", e.port ? a0.rdata : a1.rdata, cur[!e.port]);
                    cur[e.port] = e.rdata;
                end
            end
            if (b0.ack) nb0++;
            if (b1.ack) nb1++;
        end
        prev_oe = a_oe;
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic set_req(input int p, input logic r, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] we);
        if (p == 0) begin
            a0.req = r; a0.addr = addr; a0.wdata = wdata; a0.we = we;
        end else begin
            a1.req = r; a1.addr = addr; a1.wdata = wdata; a1.we = we;
        end
    endtask

    task automatic wait_ack(input int start, input int base, input string name,
                            output int lat);
        int k = 0;
        while (n_ack_a == base && k < 20) begin
            step();
            k++;
        end
        chk({name, "_ack_seen"}, 32'(n_ack_a - base), 32'd1);
        lat = ack_cyc - start;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int k = 0;
        while (n_done_a < target && k < budget) begin
            step();
            k++;
        end
        chk({name, "_done_seen"}, 32'(n_done_a >= target), 32'd1);
    endtask

    task automatic push_op(input logic p, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] we, input logic [31:0] rd);
        exp_ack.push_back(p);
        exp_cmd.push_back('{addr: addr, wdata: wdata, we: we});
        exp_done.push_back('{port: p, rdata: rd});
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int l, start, base, base_oe, base_d;
        rst = 1'b1;
        calib_done = 1'b1;
        cur[0] = 32'h0;
        cur[1] = 32'h0;
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
        b0.req = 1'b0; b0.addr = 32'h0; b0.wdata = 32'h0; b0.we = 4'h0;
        b1.req = 1'b0; b1.addr = 32'h0; b1.wdata = 32'h0; b1.we = 4'h0;
        repeat (3) step();
        chk("rst_oe", 32'(a_oe), 32'd0);
        chk("rst_addr", a_addr, 32'd0);
        chk("rst_wdata", a_wdata, 32'd0);
        chk("rst_we", 32'(a_we), 32'd0);
        chk("rst_ack", 32'({a0.ack, a1.ack}), 32'd0);
        chk("rst_done", 32'({a0.done, a1.done}), 32'd0);
        chk("rst_rdata0", a0.rdata, 32'd0);
        chk("rst_rdata1", a1.rdata, 32'd0);
        chk("rst_errs", 32'({a_eto, a_epr}), 32'd0);
        rst = 1'b0;
        step();

        // Lone p0 read, 10-cycle DRAM latency.
        lat_a = 10;
        rdv_a = 32'h1234_5678;
        push_op(1'b0, 32'h0000_0100, 32'h0, 4'h0, 32'h1234_5678);
        set_req(0, 1'b1, 32'h0000_0100, 32'h0, 4'h0);
        start = cyc;
        wait_ack(start, n_ack_a, "t1", l);
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("t1_ack_latency", 32'(l), 32'd1);
        wait_done(1, 30, "t1");
        chk("t1_done_latency", 32'(done_cyc - ack_cyc), 32'd12);

        // p1 byte write: rdata must stay at its reset value.
        lat_a = 3;
        push_op(1'b1, 32'h0000_0203, 32'h0000_00AB, 4'b0001, 32'h0);
        set_req(1, 1'b1, 32'h0000_0203, 32'h0000_00AB, 4'b0001);
        wait_ack(cyc, n_ack_a, "t2", l);
        set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
        wait_done(2, 20, "t2");

        // Both ports hold reads: round-robin on A, fixed priority on B.
        lat_a = 2;
        rdv_a = 32'hCAFE_0001;
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) push_op(1'b0, 32'h0000_1000, 32'h0, 4'h0, 32'hCAFE_0001);
            else push_op(1'b1, 32'h0000_2000, 32'h0, 4'h0, 32'hCAFE_0001);
        end
        base = n_ack_a;
        base_d = n_done_a;
        set_req(0, 1'b1, 32'h0000_1000, 32'h0, 4'h0);
        set_req(1, 1'b1, 32'h0000_2000, 32'h0, 4'h0);
        b0.req = 1'b1;
        b1.req = 1'b1;
        for (int k = 0; k < 60 && n_ack_a < base + 4; k++) step();
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_req(1, 1'b0, 32'h0, 32'h0, 4'h0);
        b0.req = 1'b0;
        b1.req = 1'b0;
        chk("t3_four_acks", 32'(n_ack_a - base), 32'd4);
        wait_done(base_d + 4, 20, "t3");
        chk("fp_p1_starved", 32'(nb1), 32'd0);
        chk("fp_p0_wins", 32'(nb0 >= 3), 32'd1);
        b1.req = 1'b1;
        for (int k = 0; k < 20 && nb1 == 0; k++) step();
        b1.req = 1'b0;
        chk("fp_p1_alone", 32'(nb1), 32'd1);
        repeat (6) step();

        // Calibration gate.
        calib_done = 1'b0;
        base = n_ack_a;
        base_oe = n_oe_a;
        set_req(0, 1'b1, 32'h0000_0300, 32'h0, 4'h0);
        repeat (20) step();
        chk("calib_no_ack", 32'(n_ack_a - base), 32'd0);
        chk("calib_no_oe", 32'(n_oe_a - base_oe), 32'd0);
        rdv_a = 32'h55AA_55AA;
        push_op(1'b0, 32'h0000_0300, 32'h0, 4'h0, 32'h55AA_55AA);
        calib_done = 1'b1;
        wait_ack(cyc, n_ack_a, "t4", l);
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        chk("calib_ack_latency", 32'(l), 32'd1);
        wait_done(base_d + 5, 20, "t4");

        // Watchdog: busy stuck high.
        stuck_a = 1'b1;
        rdv_a = 32'h0BAD_F00D;
        push_op(1'b0, 32'h0000_0400, 32'h0, 4'h0, 32'hDEAD_BEEF);
        set_req(0, 1'b1, 32'h0000_0400, 32'h0, 4'h0);
        wait_ack(cyc, n_ack_a, "t5", l);
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        wait_done(base_d + 6, 40, "t5");
        chk("wd_done_latency", 32'(done_cyc - ack_cyc), 32'd17);
        chk("wd_err_timeout", 32'(a_eto), 32'd1);
        base = n_ack_a;
        set_req(0, 1'b1, 32'h0000_0500, 32'h0, 4'h0);
        repeat (10) step();
        chk("wd_no_grant_busy", 32'(n_ack_a - base), 32'd0);
        push_op(1'b0, 32'h0000_0500, 32'h0, 4'h0, 32'h0BAD_F00D);
        stuck_a = 1'b0;
        wait_ack(cyc, base, "t5b", l);
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        wait_done(base_d + 7, 20, "t5b");
        chk("wd_no_proto", 32'(a_epr), 32'd0);

        // Illegal mask: acked, no strobe, error data next cycle.
        base_oe = n_oe_a;
        exp_ack.push_back(1'b0);
        exp_done.push_back('{port: 1'b0, rdata: 32'hDEAD_BEEF});
        set_req(0, 1'b1, 32'h0000_0600, 32'h1, 4'b0100);
        wait_ack(cyc, n_ack_a, "t6", l);
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        wait_done(base_d + 8, 10, "t6");
        chk("bad_mask_done_latency", 32'(done_cyc - ack_cyc), 32'd1);
        chk("bad_mask_no_oe", 32'(n_oe_a - base_oe), 32'd0);
        chk("bad_mask_err_proto", 32'(a_epr), 32'd1);

        // Reset in WAIT, then a stale valid must not complete anything.
        lat_a = 8;
        exp_ack.push_back(1'b0);
        exp_cmd.push_back('{addr: 32'h0000_0700, wdata: 32'h0, we: 4'h0});
        set_req(0, 1'b1, 32'h0000_0700, 32'h0, 4'h0);
        wait_ack(cyc, n_ack_a, "t7", l);
        set_req(0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (3) step();
        rst = 1'b1;
        #1;
        chk("mid_rst_oe", 32'(a_oe), 32'd0);
        chk("mid_rst_addr", a_addr, 32'd0);
        chk("mid_rst_we", 32'(a_we), 32'd0);
        chk("mid_rst_rdata0", a0.rdata, 32'd0);
        chk("mid_rst_done", 32'({a0.done, a1.done}), 32'd0);
        chk("mid_rst_errs", 32'({a_eto, a_epr}), 32'd0);
        cur[0] = 32'h0;
        cur[1] = 32'h0;
        step();
        rst = 1'b0;
        base_d = n_done_a;
        repeat (15) step();
        chk("stale_valid_no_done", 32'(n_done_a - base_d), 32'd0);
        chk("stale_valid_no_proto", 32'(a_epr), 32'd0);

        chk("left_acks", 32'(exp_ack.size()), 32'd0);
        chk("left_cmds", 32'(exp_cmd.size()), 32'd0);
        chk("left_dones", 32'(exp_done.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dram_port_arbiter.md
Name: dram_port_arbiter

Overview:
- Shares the single-word DRAM port (dram_oe/addr/wdata/we → rdata/valid/busy) between two requesters: port 0 = data memory stage, port 1 = instruction fetch / loader.
- Sequences one transaction at a time: grant, one-cycle command strobe, wait for completion, then route the response to the owner.
- Adds calibration gating, round-robin or fixed priority, a completion watchdog, and protocol-error detection.

Parameters:
- FIXED_PRIO, 0, 1 = port 0 always wins; 0 = round-robin on simultaneous requests.
- TIMEOUT_CYC, 4096, WAIT-state watchdog limit in cycles; 0 disables the watchdog.
- ERR_RDATA, 32'hDEADBEEF, rdata returned on timeout or protocol error.

Ports:
- clk  in  1  system clock; all logic in this domain.
- rst  in  1  asynchronous, active-high reset.
- calib_done  in  1  DRAM calibration complete; no grant while low.
- pN_req  in  1  (N=0,1) request, level; held until pN_ack.
- pN_addr  in  32  byte address.
- pN_wdata  in  32  write data, unshifted.
- pN_we  in  4  unshifted byte mask (0 = read; 0001/0011/1111 = write).
- pN_ack  out  1  one-cycle accept pulse.
- pN_done  out  1  one-cycle completion pulse (reads and writes).
- pN_rdata  out  32  read data; valid with pN_done on reads.
- dram_oe  out  1  one-cycle command strobe.
- dram_addr  out  32  forwarded address.
- dram_wdata  out  32  forwarded write data.
- dram_we  out  4  forwarded byte mask.
- dram_rdata  in  32  read data from the DRAM port.
- dram_valid  in  1  read-complete pulse.
- dram_busy  in  1  transaction in flight.
- err_timeout  out  1  sticky: watchdog fired.
- err_proto  out  1  sticky: illegal mask seen.

Behaviour:
- Reset values: state=IDLE; dram_oe=0; dram_addr, dram_wdata and dram_we =0; pN_ack, pN_done and pN_rdata =0; err flags=0; rr pointer=port 0; owner=0; watchdog=0.
- IDLE: grant is allowed only if calib_done && !dram_busy && some pN_req.
  - Winner: FIXED_PRIO, or only one request → lower index / the single requester.
  - Otherwise → port opposite the last granted one; the pointer flips on every grant.
- Grant at edge t:
  - Register owner, dram_addr, dram_wdata, dram_we.
  - dram_oe=1 and pN_ack=1 during cycle t+1; state=CMD.
- CMD (exactly 1 cycle): dram_oe falls at the next edge; state=WAIT; watchdog cleared. A pN_req still high during CMD is ignored and not treated as a new request.
- WAIT: ends on the first cycle with dram_busy==0.
  - At that edge: owner's pN_done=1 (one cycle); pN_rdata=dram_rdata if the op was a read, otherwise unchanged; state=IDLE.
  - A new grant may be decided in that same IDLE cycle, so back-to-back transactions issue every 3 cycles plus DRAM latency.
- dram_valid is a consistency check only: dram_busy falling on a read must coincide with dram_valid.
  - Mismatch → set err_proto.
  - dram_valid while in IDLE/CMD is ignored.
- Watchdog (TIMEOUT_CYC>0): increments each WAIT cycle. On reaching TIMEOUT_CYC:
  - set err_timeout; owner gets pN_done with pN_rdata=ERR_RDATA; state=IDLE.
  - IDLE still waits for !dram_busy before the next grant.
- Illegal mask: pN_we nonzero with pN_we[0]==0, or not in {0001,0011,1111}.
  - Request is acked as normal, but no DRAM command is issued.
  - err_proto set; pN_done pulses the cycle after ack with rdata=ERR_RDATA.
- Reset mid-operation: arbiter returns to IDLE immediately. The downstream transaction may still be in flight; the first grant after reset waits for dram_busy==0, and any stale dram_valid is discarded.
- calib_done falling in CMD/WAIT: the current op completes normally; no new grants.
- Address alignment is not checked; the DRAM port handles the byte shift.

Decomposition:
- Shared package:
  - state enum {IDLE, CMD, WAIT, ERRDONE}.
  - mask legality constants (WE_B=4'b0001, WE_H=4'b0011, WE_W=4'b1111).
  - ERR_RDATA default.
- One natural sub-module, rr_arb2: 2-way grant with FIXED_PRIO and pointer update. Everything else stays in the top.

Test Plan:
- p0 read 0x0000_0100 alone, DRAM model busy for 10 cycles returning 0x1234_5678 → p0_ack at t+1; dram_oe high exactly 1 cycle; p0_done and p0_rdata=0x1234_5678 one cycle after busy falls; p1 untouched.
- p0 and p1 both request reads, FIXED_PRIO=0, held for 4 transactions → grants alternate p0,p1,p0,p1; with FIXED_PRIO=1, p0 wins all while held.
- p1 write addr 0x0000_0203, we=0001, wdata=0xAB → dram_we=0001, dram_wdata=0x0000_00AB, dram_addr=0x0000_0203; p1_done pulses; p1_rdata unchanged.
- calib_done=0 with p0_req high for 20 cycles → no ack, no dram_oe; raise calib_done → ack next cycle.
- TIMEOUT_CYC=16, DRAM busy stuck high → p0_done at WAIT cycle 16 with rdata=0xDEADBEEF; err_timeout=1; next request not granted until busy drops.
- p0 we=0100 → ack, no dram_oe, p0_done next cycle with 0xDEADBEEF, err_proto=1; assert rst during WAIT → all outputs at reset values; a stale dram_valid after reset produces no pN_done.
